ceespu_dmem_arbiter: RTL and testbench
======================================

// Module: ceespu_dmem_arbiter
// PURPOSE
//   Shares one single-port synchronous data RAM (1-cycle read latency) between the ceespu data port
//   and a DMA/boot-loader master. Drives the core's I_dmemBusy stall and I_dmemData.
//   Arbitration is round-robin. DMA bursts are capped so that the CPU is never starved.
//   Sits between ceespu's O_dmem*/I_dmem* pins and the data RAM macro.
// PARAMETERS
//   ADDR_W     12  RAM word-address width (RAM depth = 2**ADDR_W words of 32 bits)
//   BURST_MAX  4   max consecutive DMA beats while a CPU request is pending (range 1..15)
// PORTS
//   I_clk          in   1        clock, all state on rising edge
//   I_rst          in   1        asynchronous reset, active-high
//   I_cpuE         in   1        CPU access request (ceespu O_dmemE)
//   I_cpuWe        in   4        CPU byte write enables, 0 = read
//   I_cpuAddress   in   16       CPU byte address
//   I_cpuWData     in   32       CPU write data
//   O_cpuRData     out  32       CPU read data (to ceespu I_dmemData)
//   O_cpuBusy      out  1        CPU stall (to ceespu I_dmemBusy)
//   I_dmaReq       in   1        DMA access request, held until granted
//   I_dmaWe        in   4        DMA byte write enables, 0 = read
//   I_dmaAddress   in   16       DMA byte address
//   I_dmaWData     in   32       DMA write data
//   O_dmaGnt       out  1        DMA beat accepted this cycle
//   O_dmaRData     out  32       DMA read data
//   O_dmaValid     out  1        O_dmaRData valid (1 cycle after a granted DMA read)
//   O_ramE         out  1        RAM enable
//   O_ramWe        out  4        RAM byte write enables
//   O_ramAddress   out  ADDR_W   RAM word address = selected byte address[ADDR_W+1:2]
//   O_ramWData     out  32       RAM write data
//   I_ramRData     in   32       RAM read data, valid the cycle after O_ramE with O_ramWe==0
// BEHAVIOUR
//   Registered state: last_q (0=CPU, 1=DMA), burst_q (4b), rd_cpu_q, rd_dma_q, cpu_hold_q, dma_hold_q.
//   Grant is combinational from the requests and registered state:
//     - only one requester active -> it wins
//     - both active, last_q=CPU -> DMA wins
//     - both active, last_q=DMA -> DMA wins while burst_q<BURST_MAX, otherwise CPU wins
//   On the edge: the winner sets last_q.
//     - burst_q increments on each DMA win with I_cpuE=1, saturating at BURST_MAX
//     - burst_q clears on any CPU win, or on a DMA win with I_cpuE=0
//   O_cpuBusy = I_cpuE & ~cpu_win. O_dmaGnt = dma_win. Both are combinational, zero-cycle.
//   RAM mux: the winner's We/address/WData drive the RAM and O_ramE=1. With no winner:
//     O_ramE=0, O_ramWe=0, address/WData hold the CPU values.
//   Reads:
//     - rd_cpu_q <= cpu_win & (I_cpuWe==0); rd_dma_q likewise for DMA
//     - O_cpuRData = rd_cpu_q ? I_ramRData : cpu_hold_q; cpu_hold_q captures I_ramRData when rd_cpu_q
//     - O_dmaRData follows the same scheme with rd_dma_q/dma_hold_q; O_dmaValid = rd_dma_q
//   Latency: uncontended CPU read -> data on O_cpuRData the next cycle, no stall.
//     Worst-case CPU wait is BURST_MAX cycles.
//   Address: bits above ADDR_W+1 are ignored (wrap modulo RAM size). Bits [1:0] are ignored.
//   Writes return no data. A granted write updates the RAM at that edge.
//   Back-to-back CPU beats: a read followed by another access in the next cycle is legal.
//     The RAM output is consumed in the same cycle as the new request.
//   Reset (async, any cycle, including mid-burst):
//     - all registers clear: last_q=CPU, burst_q=0, rd_*=0, hold=0
//     - while I_rst=1, all grants are forced 0: O_ramE=0, O_ramWe=0, O_cpuBusy=0, O_dmaGnt=0,
//       O_dmaValid=0, O_cpuRData=0, O_dmaRData=0
//     - a read in flight when reset asserts is discarded
// TESTING
//   1 CPU only: read of word 0x10 (RAM=0xDEADBEEF), I_cpuAddress=0x0040
//       -> O_ramAddress=0x10, O_cpuBusy=0, O_cpuRData=0xDEADBEEF next cycle.
//   2 Simultaneous first requests after reset: CPU read 0x04, DMA write 0x08 with 0x12345678
//       -> DMA granted cycle 0, CPU busy 1 cycle, CPU granted cycle 1.
//   3 DMA holds I_dmaReq for 10 beats, CPU requests continuously (BURST_MAX=4)
//       -> grant pattern DMA,DMA,DMA,DMA,CPU,DMA..., O_cpuBusy never >4 consecutive cycles.
//   4 Byte write: CPU We=4'b0010, WData=0x0000AB00 to a word holding 0x11223344
//       -> readback 0x1122AB44. Address 0xFFFC with ADDR_W=12 -> O_ramAddress=0xFFF.
//   5 Assert I_rst mid-burst, in the cycle after a DMA read grant
//       -> O_dmaValid=0, all outputs 0 immediately. After release, the first simultaneous
//          request goes to DMA (last_q=CPU).
//   6 DMA read 0x20 (0xCAFEF00D) with CPU idle
//       -> O_dmaGnt=1, next cycle O_dmaValid=1 with 0xCAFEF00D; burst_q stays 0.

Source files
------------

// File: rtl/ceespu_dmem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between the ceespu data port
// and a DMA/boot-loader master; DMA bursts are capped at BURST_MAX beats while the CPU waits.
module ceespu_dmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int BURST_MAX = 4
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_cpuE,
  input  logic [3:0]        I_cpuWe,
  input  logic [15:0]       I_cpuAddress,
  input  logic [31:0]       I_cpuWData,
  output logic [31:0]       O_cpuRData,
  output logic              O_cpuBusy,
  input  logic              I_dmaReq,
  input  logic [3:0]        I_dmaWe,
  input  logic [15:0]       I_dmaAddress,
  input  logic [31:0]       I_dmaWData,
  output logic              O_dmaGnt,
  output logic [31:0]       O_dmaRData,
  output logic              O_dmaValid,
  output logic              O_ramE,
  output logic [3:0]        O_ramWe,
  output logic [ADDR_W-1:0] O_ramAddress,
  output logic [31:0]       O_ramWData,
  input  logic [31:0]       I_ramRData
);

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  logic        last_q, last_d;
  logic [3:0]  burst_q, burst_d;
  logic        rd_cpu_q, rd_cpu_d;
  logic        rd_dma_q, rd_dma_d;
  logic [31:0] cpu_hold_q, cpu_hold_d;
  logic [31:0] dma_hold_q, dma_hold_d;

  logic        cpu_act_s, dma_act_s;
  logic        cpu_win_s, dma_win_s;

  // Address bits outside the RAM word index are deliberately dropped.
  logic        unused_addr_s;
  assign unused_addr_s = ^{I_cpuAddress[15:ADDR_W+2], I_cpuAddress[1:0],
                           I_dmaAddress[15:ADDR_W+2], I_dmaAddress[1:0]};

  // Grant decision; reset masks both requests so nothing reaches the RAM.
  always_comb begin
    cpu_act_s = I_cpuE & ~I_rst;
    dma_act_s = I_dmaReq & ~I_rst;
    cpu_win_s = 1'b0;
    dma_win_s = 1'b0;
    case ({cpu_act_s, dma_act_s})
      2'b10: cpu_win_s = 1'b1;
      2'b01: dma_win_s = 1'b1;
      2'b11: begin
        if (!last_q) begin
          dma_win_s = 1'b1;
        end else if (burst_q < BURST_LIM) begin
          dma_win_s = 1'b1;
        end else begin
          cpu_win_s = 1'b1;
        end
      end
      default: begin
        cpu_win_s = 1'b0;
        dma_win_s = 1'b0;
      end
    endcase
  end

  // Next-state for round-robin history, burst counter and read-return tracking.
  always_comb begin
    last_d     = last_q;
    burst_d    = burst_q;
    rd_cpu_d   = cpu_win_s & (I_cpuWe == 4'b0000);
    rd_dma_d   = dma_win_s & (I_dmaWe == 4'b0000);
    cpu_hold_d = rd_cpu_q ? I_ramRData : cpu_hold_q;
    dma_hold_d = rd_dma_q ? I_ramRData : dma_hold_q;
    if (cpu_win_s) begin
      last_d  = 1'b0;
      burst_d = 4'd0;
    end else if (dma_win_s) begin
      last_d = 1'b1;
      // The burst only counts against the cap while the CPU is actually waiting.
      if (I_cpuE) begin
        burst_d = (burst_q < BURST_LIM) ? (burst_q + 4'd1) : burst_q;
      end else begin
        burst_d = 4'd0;
      end
    end else begin
      last_d  = last_q;
      burst_d = burst_q;
    end
  end

  // State registers.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      last_q     <= 1'b0;
      burst_q    <= 4'd0;
      rd_cpu_q   <= 1'b0;
      rd_dma_q   <= 1'b0;
      cpu_hold_q <= 32'h0000_0000;
      dma_hold_q <= 32'h0000_0000;
    end else begin
      last_q     <= last_d;
      burst_q    <= burst_d;
      rd_cpu_q   <= rd_cpu_d;
      rd_dma_q   <= rd_dma_d;
      cpu_hold_q <= cpu_hold_d;
      dma_hold_q <= dma_hold_d;
    end
  end

  // RAM port mux; idle cycles park the address/data on the CPU side.
  always_comb begin
    O_ramE       = 1'b0;
    O_ramWe      = 4'b0000;
    O_ramAddress = I_cpuAddress[ADDR_W+1:2];
    O_ramWData   = I_cpuWData;
    if (dma_win_s) begin
      O_ramE       = 1'b1;
      O_ramWe      = I_dmaWe;
      O_ramAddress = I_dmaAddress[ADDR_W+1:2];
      O_ramWData   = I_dmaWData;
    end else if (cpu_win_s) begin
      O_ramE       = 1'b1;
      O_ramWe      = I_cpuWe;
      O_ramAddress = I_cpuAddress[ADDR_W+1:2];
      O_ramWData   = I_cpuWData;
    end else begin
      O_ramE  = 1'b0;
      O_ramWe = 4'b0000;
    end
  end

  // Master-side handshakes and read data; RAM output is forwarded in its valid cycle, then held.
  always_comb begin
    O_cpuBusy  = cpu_act_s & ~cpu_win_s;
    O_dmaGnt   = dma_win_s;
    O_dmaValid = rd_dma_q;
    O_cpuRData = rd_cpu_q ? I_ramRData : cpu_hold_q;
    O_dmaRData = rd_dma_q ? I_ramRData : dma_hold_q;
  end

endmodule

// File: tb/tb_ceespu_dmem_arbiter.sv
// Scoreboard bench for ceespu_dmem_arbiter: directed stimulus pushes expected grants and read data,
// a negedge monitor pops and compares them as the DUT presents RAM grants and read returns.
module tb_ceespu_dmem_arbiter;
  localparam int ADDR_W    = 12;
  localparam int BURST_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_e = 1'b0;
  logic [3:0]  cpu_we = 4'h0;
  logic [15:0] cpu_addr = 16'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_busy;
  logic        dma_req = 1'b0;
  logic [3:0]  dma_we = 4'h0;
  logic [15:0] dma_addr = 16'h0;
  logic [31:0] dma_wdata = 32'h0;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_valid;
  logic        ram_e;
  logic [3:0]  ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  typedef struct packed {
    logic        dma;
    logic [11:0] addr;
    logic [3:0]  we;
  } gnt_t;

  gnt_t        exp_gnt[$];
  logic [31:0] exp_cpu[$];
  logic [31:0] exp_dma[$];
  int          n_cmp = 0;
  int          n_err = 0;

  ceespu_dmem_arbiter #(.ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) dut (
    .I_clk(clk), .I_rst(rst),
    .I_cpuE(cpu_e), .I_cpuWe(cpu_we), .I_cpuAddress(cpu_addr), .I_cpuWData(cpu_wdata),
    .O_cpuRData(cpu_rdata), .O_cpuBusy(cpu_busy),
    .I_dmaReq(dma_req), .I_dmaWe(dma_we), .I_dmaAddress(dma_addr), .I_dmaWData(dma_wdata),
    .O_dmaGnt(dma_gnt), .O_dmaRData(dma_rdata), .O_dmaValid(dma_valid),
    .O_ramE(ram_e), .O_ramWe(ram_we), .O_ramAddress(ram_addr), .O_ramWData(ram_wdata),
    .I_ramRData(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with byte enables and 1-cycle read latency.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_e) begin
      if (ram_we == 4'h0) begin
        ram_rdata <= mem[ram_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every RAM grant, every DMA read return and every CPU read return.
  logic cpu_rd_pend = 1'b0;
  int   busy_run = 0;
  gnt_t mg;
  always @(negedge clk) begin
    if (cpu_rd_pend) begin
      if (exp_cpu.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL cpu_rdata: unexpected read return 0x%08h, none expected", cpu_rdata);
      end else begin
        chk("cpu_rdata", cpu_rdata, exp_cpu.pop_front());
      end
    end
    if (dma_valid) begin
      if (exp_dma.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dma_valid: unexpected 0x%08h, none expected", dma_rdata);
      end else begin
        chk("dma_rdata", dma_rdata, exp_dma.pop_front());
      end
    end
    if (ram_e) begin
      if (exp_gnt.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL gnt: unexpected grant dma=%0b addr=0x%03h, none expected", dma_gnt, ram_addr);
      end else begin
        mg = exp_gnt.pop_front();
        chk("gnt_src", {31'h0, dma_gnt}, {31'h0, mg.dma});
        chk("gnt_addr", {20'h0, ram_addr}, {20'h0, mg.addr});
        chk("gnt_we", {28'h0, ram_we}, {28'h0, mg.we});
      end
    end
    cpu_rd_pend = !rst && cpu_e && !cpu_busy && (cpu_we == 4'h0);
    if (cpu_busy) begin
      busy_run++;
    end else begin
      if (busy_run > 0) begin
        n_cmp++;
        if (busy_run > BURST_MAX) begin
          n_err++;
          $display("FAIL busy_run: %0d consecutive stall cycles, limit %0d", busy_run, BURST_MAX);
        end
      end
      busy_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic idle();
    cpu_e = 1'b0; cpu_we = 4'h0; dma_req = 1'b0; dma_we = 4'h0;
  endtask
  task automatic cpu_set(input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
    cpu_e = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask
  task automatic dma_set(input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask
  task automatic push_g(input logic dma, input logic [11:0] a, input logic [3:0] we);
    gnt_t g;
    g.dma = dma; g.addr = a; g.we = we;
    exp_gnt.push_back(g);
  endtask
  task automatic pulse_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_ramE"}, {31'h0, ram_e}, 32'h0);
    chk({tag, "_ramWe"}, {28'h0, ram_we}, 32'h0);
    chk({tag, "_busy"}, {31'h0, cpu_busy}, 32'h0);
    chk({tag, "_dmaGnt"}, {31'h0, dma_gnt}, 32'h0);
    chk({tag, "_dmaValid"}, {31'h0, dma_valid}, 32'h0);
    chk({tag, "_cpuRData"}, cpu_rdata, 32'h0);
    chk({tag, "_dmaRData"}, dma_rdata, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:12] pat3;
    logic [0:5]  pat6;
    int k, beats, db;
    logic cpu_done;

    // Reset state: outputs forced low even with both requests asserted.
    cpu_set(4'h0, 16'h0040, 32'h0);
    dma_set(4'h0, 16'h0020, 32'h0);
    @(negedge clk);
    chk_all_zero("rst");
    tick(); idle(); rst = 1'b0; tick();

    // 1: uncontended CPU read, data next cycle without stall.
    mem[12'h010] = 32'hDEADBEEF;
    cpu_set(4'h0, 16'h0040, 32'h0);
    push_g(1'b0, 12'h010, 4'h0);
    exp_cpu.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("t1_busy", {31'h0, cpu_busy}, 32'h0);
    chk("t1_addr", {20'h0, ram_addr}, 32'h10);
    tick(); idle(); @(negedge clk); tick();

    // 2: simultaneous first requests after reset go to DMA, then CPU.
    pulse_reset();
    mem[12'h001] = 32'hA5A50001;
    mem[12'h002] = 32'h0;
    cpu_set(4'h0, 16'h0004, 32'h0);
    dma_set(4'hF, 16'h0008, 32'h12345678);
    push_g(1'b1, 12'h002, 4'hF);
    @(negedge clk);
    chk("t2_busy0", {31'h0, cpu_busy}, 32'h1);
    chk("t2_gnt0", {31'h0, dma_gnt}, 32'h1);
    tick();
    dma_req = 1'b0;
    push_g(1'b0, 12'h001, 4'h0);
    exp_cpu.push_back(32'hA5A50001);
    @(negedge clk);
    chk("t2_busy1", {31'h0, cpu_busy}, 32'h0);
    tick(); idle();
    dma_set(4'h0, 16'h0008, 32'h0);
    push_g(1'b1, 12'h002, 4'h0);
    exp_dma.push_back(32'h12345678);
    @(negedge clk); tick(); idle(); @(negedge clk); tick();

    // 3: 10-beat DMA burst against a continuously requesting CPU.
    pulse_reset();
    mem[12'h000] = 32'h0BADF00D;
    pat3 = 13'b1111011110110;
    k = 0;
    for (int i = 0; i < 13; i++) begin
      if (pat3[i]) begin
        push_g(1'b1, 12'(12'h040 + k), 4'hF);
        k++;
      end else begin
        push_g(1'b0, 12'h000, 4'h0);
        exp_cpu.push_back(32'h0BADF00D);
      end
    end
    beats = 0;
    for (int i = 0; i < 13; i++) begin
      cpu_set(4'h0, 16'h0000, 32'h0);
      if (beats < 10) dma_set(4'hF, 16'(16'h0100 + 4 * beats), 32'(beats));
      else dma_req = 1'b0;
      @(negedge clk);
      if (dma_gnt) beats++;
      tick();
    end
    idle(); @(negedge clk); tick();
    chk("t3_beats", 32'(beats), 32'd10);

    // 4: byte-lane write, back-to-back reads, address wrap.
    mem[12'h003] = 32'h11223344;
    mem[12'hFFF] = 32'h600DCAFE;
    cpu_set(4'b0010, 16'h000C, 32'h0000AB00);
    push_g(1'b0, 12'h003, 4'b0010);
    tick();
    cpu_set(4'h0, 16'h000C, 32'h0);
    push_g(1'b0, 12'h003, 4'h0);
    exp_cpu.push_back(32'h1122AB44);
    @(negedge clk); tick();
    cpu_set(4'h0, 16'hFFFC, 32'h0);
    push_g(1'b0, 12'hFFF, 4'h0);
    exp_cpu.push_back(32'h600DCAFE);
    @(negedge clk);
    chk("t4_wrap", {20'h0, ram_addr}, 32'hFFF);
    tick(); idle(); @(negedge clk); tick();

    // 6: lone DMA read leaves the burst counter at zero, so a full cap follows.
    mem[12'h008] = 32'hCAFEF00D;
    dma_set(4'h0, 16'h0020, 32'h0);
    push_g(1'b1, 12'h008, 4'h0);
    exp_dma.push_back(32'hCAFEF00D);
    @(negedge clk);
    chk("t6_gnt", {31'h0, dma_gnt}, 32'h1);
    chk("t6_busy", {31'h0, cpu_busy}, 32'h0);
    tick(); idle();
    @(negedge clk);
    chk("t6_valid", {31'h0, dma_valid}, 32'h1);
    chk("t6_rdata", dma_rdata, 32'hCAFEF00D);
    tick();
    pat6 = 6'b111101;
    for (int i = 0; i < 6; i++) begin
      if (pat6[i]) begin
        push_g(1'b1, 12'h008, 4'h0);
        exp_dma.push_back(32'hCAFEF00D);
      end else begin
        push_g(1'b0, 12'h000, 4'h0);
        exp_cpu.push_back(32'h0BADF00D);
      end
    end
    cpu_done = 1'b0; db = 0;
    for (int i = 0; i < 6; i++) begin
      if (!cpu_done) cpu_set(4'h0, 16'h0000, 32'h0);
      else cpu_e = 1'b0;
      if (db < 5) dma_set(4'h0, 16'h0020, 32'h0);
      else dma_req = 1'b0;
      @(negedge clk);
      if (dma_gnt) db++;
      if (cpu_e && !cpu_busy) cpu_done = 1'b1;
      tick();
    end
    idle(); @(negedge clk); tick();
    chk("t6_beats", 32'(db), 32'd5);

    // 5: reset lands in the cycle after a DMA read grant at the burst cap.
    cpu_set(4'hF, 16'h0010, 32'h0);
    push_g(1'b0, 12'h004, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      cpu_set(4'h0, 16'h0000, 32'h0);
      dma_set(4'h0, 16'h0020, 32'h0);
      push_g(1'b1, 12'h008, 4'h0);
      if (i < 3) exp_dma.push_back(32'hCAFEF00D);
      @(negedge clk); tick();
    end
    rst = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    tick();
    rst = 1'b0;
    push_g(1'b1, 12'h008, 4'h0);
    exp_dma.push_back(32'hCAFEF00D);
    @(negedge clk);
    chk("t5_dma_first", {31'h0, dma_gnt}, 32'h1);
    tick();
    dma_req = 1'b0;
    push_g(1'b0, 12'h000, 4'h0);
    exp_cpu.push_back(32'h0BADF00D);
    @(negedge clk); tick(); idle(); @(negedge clk); tick(); tick();

    chk("gnt_q_empty", 32'(exp_gnt.size()), 32'd0);
    chk("cpu_q_empty", 32'(exp_cpu.size()), 32'd0);
    chk("dma_q_empty", 32'(exp_dma.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
